ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the single-port RAM (clock_ram strobe, wren, a_ram) between two requesters:
//  port 0 is the ROM->RAM copy engine and port 1 is the RAM readback/reader.
//  Round-robin grant. Each granted transaction is a fixed 4-cycle sequence:
//  address setup, clock_ram strobe, data capture and acknowledge.
//  Sits between the requester FSMs and the RAM macro, and is the only driver of the RAM control pins.
// PARAMETERS
//  ADDR_W  5  RAM address width (32 words)
//  DATA_W  8  RAM data width
// PORTS
//  clock      in   1       system clock; all state changes on posedge
//  reset      in   1       synchronous, active-high; sampled on posedge clock
//  req0       in   1       port 0 request; hold high until ack0
//  we0        in   1       port 0 write enable (1=write, 0=read)
//  addr0      in   ADDR_W  port 0 address
//  wdata0     in   DATA_W  port 0 write data
//  ack0       out  1       1-cycle pulse: port 0 transaction complete
//  req1/we1/addr1/wdata1/ack1   same as port 0, for port 1
//  rdata      out  DATA_W  read data; valid while ack0 or ack1 is high; holds until next capture
//  busy       out  1       high in every state except IDLE
//  a_ram      out  ADDR_W  RAM address
//  d_ram      out  DATA_W  RAM write data
//  wren       out  1       RAM write enable
//  clock_ram  out  1       RAM clock strobe; high only in STROBE
//  q_ram      in   DATA_W  RAM read data
// BEHAVIOUR
//  - FSM states: IDLE -> SETUP -> STROBE -> DONE -> IDLE. All outputs are registered or decoded from state.
//  - IDLE
//    - Samples req0/req1 at the posedge.
//    - One request: grant that port. Both requests: grant the port that is not last_gnt.
//    - At grant, latch the winner's we/addr/wdata into internal registers, store sel, update last_gnt, go to SETUP.
//    - No request: stay in IDLE.
//  - SETUP: a_ram, d_ram and wren driven from the latched registers; clock_ram=0.
//  - STROBE: same a_ram, d_ram and wren as SETUP; clock_ram=1.
//  - DONE
//    - clock_ram=0; wren=0; a_ram holds its value.
//    - Read: rdata <= q_ram at the edge entering DONE.
//    - ack of the granted port =1 for exactly this cycle. The other ack stays 0.
//    - Next state is always IDLE.
//  - Req to ack latency: 3 cycles after the IDLE grant edge. Back-to-back service needs 4 cycles/transaction.
//  - Requester protocol
//    - Drop req in the cycle after ack.
//    - Changing we/addr/wdata after the grant has no effect on the current transaction.
//    - A req dropped mid-transaction does not abort it; ack still pulses.
//  - Fairness: both ports requesting continuously alternate 0,1,0,1. Neither port waits more than one transaction.
//  - Defaults outside SETUP/STROBE: wren=0, clock_ram=0, d_ram=0.
//  - Reset (any state, including mid-transaction)
//    - State=IDLE; a_ram=0, d_ram=0, wren=0, clock_ram=0, ack0=ack1=0, rdata=0, busy=0.
//    - last_gnt=1, so port 0 wins the first tie.
//    - An aborted transaction never acks.
//    - If reset is asserted in STROBE, clock_ram is 0 in the cycle after the reset edge.
//  - Writes: rdata is left unchanged.
//  - Addresses use the full ADDR_W range (0..31); there is no wrap logic.
// TESTING
//  1. Reset, req0=1 we0=1 addr0=5 wdata0=8'hA5
//     -> SETUP a_ram=5 wren=1; STROBE clock_ram=1; DONE ack0=1 rdata=0; RAM[5]=A5.
//  2. After test 1, req1=1 we1=0 addr1=5
//     -> ack1 3 cycles after grant; rdata=8'hA5; ack0 stays 0.
//  3. req0 and req1 both held high for 8 transactions from reset
//     -> acks alternate 0,1,0,1,... with one ack every 4 cycles.
//  4. Reset asserted during STROBE of a write to addr 7
//     -> next cycle IDLE with all outputs 0; no ack.
//     -> Follow-up requester req0 on addr 9 is granted first.
//  5. req0 dropped after grant; addr0 changed 3->4 during SETUP
//     -> access still uses addr 3 and ack0 pulses.
//  6. ROM->RAM reversal using port 0 writes to 31..0, then port 1 reads 0..31
//     -> rdata sequence equals ROM[31..0]; wren never high outside SETUP/STROBE.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter that gives two requesters turns on a single-port RAM.
// Each grant runs one fixed four-cycle sequence: setup, strobe, done/ack, idle.
module ram_access_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] a_ram,
  output logic [DATA_W-1:0] d_ram,
  output logic              wren,
  output logic              clock_ram,
  input  logic [DATA_W-1:0] q_ram
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_gnt_q, last_gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   a_ram_q, a_ram_d;
  logic [DATA_W-1:0]   d_ram_q, d_ram_d;
  logic                wren_q, wren_d;
  logic                clock_ram_q, clock_ram_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic                drive_s;

  // Next-state, grant latch and registered RAM/requester outputs.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            sel_d = ~last_gnt_q;
          end else if (req1) begin
            sel_d = 1'b1;
          end else begin
            sel_d = 1'b0;
          end
          last_gnt_d = sel_d;
          if (sel_d) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    drive_s     = (state_d == SETUP) || (state_d == STROBE);
    busy_d      = (state_d != IDLE);
    clock_ram_d = (state_d == STROBE);
    ack0_d      = (state_d == DONE) && !sel_d;
    ack1_d      = (state_d == DONE) && sel_d;
    if (drive_s) begin
      wren_d  = we_d;
      d_ram_d = wdata_d;
    end else begin
      wren_d  = 1'b0;
      d_ram_d = {DATA_W{1'b0}};
    end
    if (state_d == SETUP) begin
      a_ram_d = addr_d;
    end else begin
      a_ram_d = a_ram_q;
    end
    if ((state_q == STROBE) && !we_q) begin
      rdata_d = q_ram;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      a_ram_q     <= {ADDR_W{1'b0}};
      d_ram_q     <= {DATA_W{1'b0}};
      wren_q      <= 1'b0;
      clock_ram_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      a_ram_q     <= a_ram_d;
      d_ram_q     <= d_ram_d;
      wren_q      <= wren_d;
      clock_ram_q <= clock_ram_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign a_ram     = a_ram_q;
  assign d_ram     = d_ram_q;
  assign wren      = wren_q;
  assign clock_ram = clock_ram_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a transaction-level reference model
// and a behavioural RAM clocked by the arbiter's clock_ram strobe.
module tb_ram_access_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, wren, clock_ram;
  logic [7:0] rdata, d_ram, q_ram;
  logic [4:0] a_ram;

  int checks = 0;
  int fails  = 0;

  ram_access_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .a_ram(a_ram), .d_ram(d_ram),
    .wren(wren), .clock_ram(clock_ram), .q_ram(q_ram)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM: acts on the rising edge of the strobe.
  logic [7:0] ram_mem [32];
  always @(posedge clock_ram) begin
    if (wren) ram_mem[a_ram] <= d_ram;
    else      q_ram <= ram_mem[a_ram];
  end

  // Reference model: a transaction occupies the three cycles after its grant
  // edge (offset 1 = address setup, 2 = strobe, 3 = ack), then one idle cycle.
  bit         m_ok = 1'b0;
  int         m_off;
  logic       m_last, m_sel, m_we;
  logic [4:0] m_addr, m_a;
  logic [7:0] m_wd, m_rdata;
  logic [7:0] m_mem [32];
  logic       pick;
  assign pick = (req0 && req1) ? ~m_last : req1;

  always @(posedge clock) begin
    if (reset) begin
      m_ok <= 1'b1; m_off <= -1; m_last <= 1'b1; m_rdata <= 8'h00; m_a <= 5'd0;
      m_sel <= 1'b0; m_we <= 1'b0; m_wd <= 8'h00; m_addr <= 5'd0;
    end else if (m_off < 0) begin
      if (req0 || req1) begin
        m_sel  <= pick;
        m_last <= pick;
        m_we   <= pick ? we1 : we0;
        m_addr <= pick ? addr1 : addr0;
        m_a    <= pick ? addr1 : addr0;
        m_wd   <= pick ? wdata1 : wdata0;
        m_off  <= 1;
      end
    end else if (m_off == 3) begin
      m_off <= -1;
    end else begin
      if (m_off == 2) begin
        if (m_we) m_mem[m_addr] <= m_wd;
        else      m_rdata <= m_mem[m_addr];
      end
      m_off <= m_off + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-output comparison against the model, made mid-cycle.
  task automatic cmp();
    logic        drv;
    logic [31:0] e, a;
    if (m_ok) begin
      drv = (m_off == 1) || (m_off == 2);
      e = {5'd0, m_off >= 1, m_off == 2, drv & m_we, (m_off == 3) && !m_sel,
           (m_off == 3) && m_sel, m_a, drv ? m_wd : 8'h00, m_rdata};
      a = {5'd0, busy, clock_ram, wren, ack0, ack1, a_ram, d_ram, rdata};
      chk("cycle_model", a, e);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    cmp();
    @(posedge clock);
    #1;
  endtask

  task automatic do_txn(input logic port, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd);
    int   lat;
    logic got;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      lat++;
      if (port ? ack1 : ack0) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", lat, 32'd3);
    chk("other_ack_low", {31'd0, port ? ack0 : ack1}, 32'd0);
    rd = rdata;
    if (port) req1 = 1'b0; else req0 = 1'b0;
    cyc();
  endtask

  function automatic logic [7:0] rom(input int i);
    return 8'((i * 37 + 11) ^ 8'h5A);
  endfunction

  initial begin
    logic [7:0] rd;
    int         n, first;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    cyc(); cyc();
    chk("reset_outputs", {busy, clock_ram, wren, ack0, ack1, a_ram, d_ram, rdata}, 32'd0);
    reset = 1'b0;

    // Test 1: write A5 to address 5, stage by stage.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 8'hA5;
    cyc();
    chk("t1_setup_addr", a_ram, 32'd5);
    chk("t1_setup_wren", wren, 32'd1);
    chk("t1_setup_strobe", clock_ram, 32'd0);
    cyc();
    chk("t1_strobe", clock_ram, 32'd1);
    cyc();
    chk("t1_ack0", ack0, 32'd1);
    chk("t1_rdata", rdata, 32'd0);
    chk("t1_done_wren", wren, 32'd0);
    req0 = 1'b0;
    cyc();

    // Test 2: port 1 reads address 5 back.
    do_txn(1'b1, 1'b0, 5'd5, 8'h00, rd);
    chk("t2_rdata", rd, 32'hA5);

    // Test 3: both ports request continuously from reset.
    reset = 1'b1; cyc(); reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd10; wdata0 = 8'h10;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd11; wdata1 = 8'h11;
    n = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      if (ack0 || ack1) begin
        chk("t3_ack_cycle", i, 4 * n + 3);
        chk("t3_ack_port", {30'd0, ack1, ack0}, (n % 2 == 0) ? 32'd1 : 32'd2);
        n++;
      end
    end
    chk("t3_ack_count", n, 32'd8);
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    // Test 4: reset during the strobe of a write to address 7.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h77;
    cyc(); cyc();
    chk("t4_in_strobe", clock_ram, 32'd1);
    reset = 1'b1; req0 = 1'b0;
    cyc();
    chk("t4_after_reset", {busy, clock_ram, wren, ack0, ack1, a_ram, d_ram, rdata}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("t4_no_ack", {ack0, ack1}, 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd9;  wdata0 = 8'h99;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd12; wdata1 = 8'h12;
    first = 0;
    for (int i = 0; i < 12 && first == 0; i++) begin
      cyc();
      if (ack0 || ack1) first = ack1 ? 2 : 1;
    end
    chk("t4_first_winner", first, 32'd1);
    req0 = 1'b0;
    first = 0;
    for (int i = 0; i < 12 && first == 0; i++) begin
      cyc();
      if (ack1) first = 1;
    end
    chk("t4_second_ack1", first, 32'd1);
    req1 = 1'b0;
    cyc();

    // Test 5: request changes after grant do not affect the transaction.
    do_txn(1'b1, 1'b1, 5'd3, 8'h33, rd);
    do_txn(1'b1, 1'b1, 5'd4, 8'h44, rd);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    cyc();
    req0 = 1'b0; addr0 = 5'd4;
    chk("t5_setup_addr", a_ram, 32'd3);
    cyc(); cyc();
    chk("t5_ack0", ack0, 32'd1);
    chk("t5_rdata", rdata, 32'h33);
    cyc();

    // Test 6: ROM copied in reverse by port 0, read back in order by port 1.
    for (int i = 0; i < 32; i++) do_txn(1'b0, 1'b1, 5'(31 - i), rom(i), rd);
    for (int j = 0; j < 32; j++) begin
      do_txn(1'b1, 1'b0, 5'(j), 8'h00, rd);
      chk("t6_readback", rd, {24'd0, rom(31 - j)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
